// File: rtl/wb_master_ctrl_pkg.sv
// Shared constants for the Wishbone master controller:
// default bus widths and the FSM state encoding.
package wb_master_ctrl_pkg;

  localparam int DEF_DWIDTH = 32;
  localparam int DEF_SWIDTH = 4;
  localparam int DEF_AWIDTH = 30;

  localparam int CNT_W = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_RSP  = 2'd2;

endpackage

// File: rtl/wb_master_ctrl.sv
// Single-transfer Wishbone master: accepts one command,
// runs a classic cycle with timeout, returns one response.
module wb_master_ctrl
  import wb_master_ctrl_pkg::*;
#(
  parameter int WB_DWIDTH = DEF_DWIDTH,
  parameter int WB_SWIDTH = DEF_SWIDTH,
  parameter int WB_AWIDTH = DEF_AWIDTH,
  parameter int TIMEOUT   = 16
) (
  input  logic                 i_ck,
  input  logic                 i_rst,
  input  logic                 i_cmd_valid,
  output logic                 o_cmd_ready,
  input  logic                 i_cmd_we,
  input  logic [WB_SWIDTH-1:0] i_cmd_sel,
  input  logic [WB_AWIDTH-1:0] i_cmd_adr,
  input  logic [WB_DWIDTH-1:0] i_cmd_dat,
  output logic                 o_rsp_valid,
  input  logic                 i_rsp_ready,
  output logic [WB_DWIDTH-1:0] o_rsp_dat,
  output logic                 o_rsp_err,
  output logic                 o_wb_we,
  output logic [WB_SWIDTH-1:0] o_wb_sel,
  output logic [WB_AWIDTH-1:0] o_wb_adr,
  output logic [WB_DWIDTH-1:0] o_wb_dat,
  output logic                 o_wb_cyc,
  output logic                 o_wb_stb,
  input  logic [WB_DWIDTH-1:0] i_wb_dat,
  input  logic                 i_wb_ack
);

  // Last strobe cycle index before the transfer is declared dead.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             to_hit;

  assign o_cmd_ready = (state == ST_IDLE);
  assign to_hit      = (cnt == TO_LAST);

  // Transfer FSM with all bus and response outputs registered.
  always_ff @(posedge i_ck) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      o_wb_we     <= 1'b0;
      o_wb_sel    <= '0;
      o_wb_adr    <= '0;
      o_wb_dat    <= '0;
      o_wb_cyc    <= 1'b0;
      o_wb_stb    <= 1'b0;
      o_rsp_valid <= 1'b0;
      o_rsp_dat   <= '0;
      o_rsp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_cmd_valid) begin
            o_wb_we  <= i_cmd_we;
            o_wb_sel <= i_cmd_sel;
            o_wb_adr <= i_cmd_adr;
            o_wb_dat <= i_cmd_dat;
            o_wb_cyc <= 1'b1;
            o_wb_stb <= 1'b1;
            cnt      <= '0;
            state    <= ST_BUS;
          end
        end
        ST_BUS: begin
          if (i_wb_ack) begin
            o_wb_cyc    <= 1'b0;
            o_wb_stb    <= 1'b0;
            o_rsp_dat   <= o_wb_we ? '0 : i_wb_dat;
            o_rsp_err   <= 1'b0;
            o_rsp_valid <= 1'b1;
            state       <= ST_RSP;
          end else if (to_hit) begin
            o_wb_cyc    <= 1'b0;
            o_wb_stb    <= 1'b0;
            o_rsp_dat   <= '0;
            o_rsp_err   <= 1'b1;
            o_rsp_valid <= 1'b1;
            state       <= ST_RSP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_RSP: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/wb_master_ctrl.md
WB_MASTER_CTRL -- requirements
Module: wb_master_ctrl

Interface
REQ-001 Parameter WB_DWIDTH, default 32, data bus width.
REQ-002 Parameter WB_SWIDTH, default 4, byte-select width (WB_DWIDTH/8).
REQ-003 Parameter WB_AWIDTH, default 30, word address width.
REQ-004 Parameter TIMEOUT, default 16, number of strobe cycles allowed without ack before an error (range 2..255).
REQ-005 Port i_ck  input  1  the single clock; all state changes on its rising edge.
REQ-006 Port i_rst  input  1  reset, synchronous and active-high.
REQ-007 Port i_cmd_valid  input  1  command present.
REQ-008 Port o_cmd_ready  output  1  controller can accept a command.
REQ-009 Port i_cmd_we  input  1  1 = write, 0 = read.
REQ-010 Port i_cmd_sel  input  WB_SWIDTH  byte selects.
REQ-011 Port i_cmd_adr  input  WB_AWIDTH  word address.
REQ-012 Port i_cmd_dat  input  WB_DWIDTH  write data.
REQ-013 Port o_rsp_valid  output  1  response present.
REQ-014 Port i_rsp_ready  input  1  response consumer ready.
REQ-015 Port o_rsp_dat  output  WB_DWIDTH  read data (0 for writes and errors).
REQ-016 Port o_rsp_err  output  1  transfer timed out.
REQ-017 Ports o_wb_we/o_wb_sel/o_wb_adr/o_wb_dat/o_wb_cyc/o_wb_stb  output  1/WB_SWIDTH/WB_AWIDTH/WB_DWIDTH/1/1  Wishbone master signals.
REQ-018 Ports i_wb_dat  input  WB_DWIDTH, i_wb_ack  input  1  Wishbone slave return signals.

Function
REQ-019 FSM states IDLE, BUS, RSP; reset state IDLE.
REQ-020 IDLE: o_cmd_ready=1; on i_cmd_valid at an edge, latch we/sel/adr/dat into o_wb_* registers, set o_wb_cyc=o_wb_stb=1, clear timeout counter, go BUS.
REQ-021 o_cmd_ready=0 in BUS and RSP; commands offered there are not accepted (valid/ready handshake, no loss).
REQ-022 All o_wb_* outputs are registered; o_wb_adr/sel/dat/we stable for the whole BUS state.
REQ-023 BUS: i_wb_ack sampled high at an edge -> o_wb_cyc=o_wb_stb=0, o_rsp_dat=i_wb_dat if read else 0, o_rsp_err=0, go RSP.
REQ-024 BUS without ack: counter increments each cycle; ack absent when counter equals TIMEOUT-1 -> drop cyc/stb, o_rsp_dat=0, o_rsp_err=1, go RSP.
REQ-025 Ack and timeout on the same edge: ack wins, err=0.
REQ-026 Counter width 8 bits, saturating never reached (cleared on entry to BUS).
REQ-027 RSP: o_rsp_valid=1, o_rsp_dat/o_rsp_err held; on i_rsp_ready at an edge go IDLE, o_rsp_valid=0.
REQ-028 i_wb_ack outside BUS is ignored.
REQ-029 Latency for zero-wait slave ack (combinational with stb): cmd accepted edge N, stb high cycle N+1, o_rsp_valid high from cycle N+2.
REQ-030 Read from a one-wait slave (ack second strobe cycle): o_rsp_valid from cycle N+3.
REQ-031 Minimum one cycle with o_wb_stb=0 between consecutive transfers (guaranteed by RSP and IDLE).

Reset
REQ-032 i_rst high at an edge: state IDLE, o_wb_cyc=o_wb_stb=o_wb_we=0, o_wb_sel/adr/dat=0, o_rsp_valid=0, o_rsp_dat=0, o_rsp_err=0, counter=0; o_cmd_ready=1 from first cycle after reset release.
REQ-033 Reset mid-transfer (BUS or RSP) aborts immediately; no response produced for the aborted command.

Structure
REQ-034 Shared package holds WB_DWIDTH/WB_SWIDTH/WB_AWIDTH defaults and the FSM state encoding (IDLE=0, BUS=1, RSP=2, 2 bits).
REQ-035 Single flat module; no sub-module; the existing memory-backed Wishbone test slave is the bench target.

Verification
REQ-036 Write adr=0x10, sel=0xF, dat=0xDEADBEEF, rsp_ready=1 -> stb one cycle, o_rsp_valid at N+2, err=0, rsp_dat=0.
REQ-037 Read back adr=0x10 -> o_rsp_valid at N+3, o_rsp_dat=0xDEADBEEF, err=0.
REQ-038 Write sel=0x3 dat=0x0000CAFE to 0x10 then read -> rsp_dat=0xDEADCAFE.
REQ-039 Slave ack tied 0, TIMEOUT=16 -> stb high exactly 16 cycles, then rsp_valid with err=1, rsp_dat=0.
REQ-040 rsp_ready held 0 for 5 cycles -> rsp_valid/dat stable, cmd_ready=0, second cmd not accepted until response taken.
REQ-041 i_rst asserted one cycle while stb high -> next cycle cyc=stb=0, rsp_valid=0, cmd_ready=1.
